// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: widths, state encodings
// and the default forced-switch wait threshold.
package dmem_arbiter_pkg;
  localparam int XLEN         = 32;
  localparam int ADDR_SIZE    = 32;
  localparam int DEF_MAX_WAIT = 8;
  localparam int WAIT_W       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;
endpackage

// File: rtl/dmem_arbiter_wait_counter.sv
// Counts how long the non-owner has been waiting; o_sat rises once the
// count reaches THRESH-1 and the count then holds there.
module arb_wait_counter #(
  parameter int THRESH = 8,
  parameter int W      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_sat
);
  localparam logic [W-1:0] LIM = W'(THRESH - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr)      r_cnt <= '0;
    else if (i_inc && !o_sat) r_cnt <= r_cnt + 1'b1;
  end

  assign o_sat = (r_cnt >= LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with lock and starvation-bounded ownership.
// Define DMEM_ARB_RR_EN for round-robin IDLE ties; default is port 0 priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req0,
  input  logic            req1,
  input  logic            lock0,
  input  logic            lock1,
  input  logic            we0,
  input  logic            we1,
  input  logic [3:0]      amp0,
  input  logic [3:0]      amp1,
  input  logic [XLEN-1:0] a0,
  input  logic [XLEN-1:0] a1,
  input  logic [XLEN-1:0] wd0,
  input  logic [XLEN-1:0] wd1,
  output logic            gnt0,
  output logic            gnt1,
  output logic [XLEN-1:0] rd0,
  output logic [XLEN-1:0] rd1,
  output logic            mem_we,
  output logic [3:0]      mem_amp,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);
  arb_state_e r_state, w_next;
  logic       r_last_gnt;
  logic       w_inc, w_clr, w_sat;

  assign gnt0 = (r_state == OWN0) && req0;
  assign gnt1 = (r_state == OWN1) && req1;

  // The "other" requester is waiting whenever it asks while someone else owns.
  assign w_inc = ((r_state == OWN0) && req1) || ((r_state == OWN1) && req0);
  assign w_clr = !w_inc || (w_next != r_state);

  arb_wait_counter #(.THRESH(MAX_WAIT), .W(WAIT_W)) u_wait (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_inc (w_inc),
    .o_sat (w_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state <= w_next;
      if (gnt0)      r_last_gnt <= 1'b0;
      else if (gnt1) r_last_gnt <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
          w_next = r_last_gnt ? OWN0 : OWN1;
`else
          w_next = OWN0;
`endif
        end
        else if (req0) w_next = OWN0;
        else if (req1) w_next = OWN1;
        else           w_next = IDLE;
      end
      OWN0: begin
        if (!req0)                        w_next = req1 ? OWN1 : IDLE;
        else if (req1 && (!lock0 || w_sat)) w_next = OWN1;
        else                              w_next = OWN0;
      end
      OWN1: begin
        if (!req1)                        w_next = req0 ? OWN0 : IDLE;
        else if (req0 && (!lock1 || w_sat)) w_next = OWN0;
        else                              w_next = OWN1;
      end
      default: w_next = IDLE;
    endcase
  end

  // Memory port is purely combinational from the granted requester.
  always_comb begin
    mem_we  = 1'b0;
    mem_amp = '0;
    mem_a   = '0;
    mem_wd  = '0;
    if (gnt0) begin
      mem_we  = we0;
      mem_amp = amp0;
      mem_a   = a0;
      mem_wd  = wd0;
    end else if (gnt1) begin
      mem_we  = we1;
      mem_amp = amp1;
      mem_a   = a1;
      mem_wd  = wd1;
    end
  end

  assign rd0 = gnt0 ? mem_rd : '0;
  assign rd1 = gnt1 ? mem_rd : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a small byte-lane data memory model.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, lock0, lock1, we0, we1;
  logic [3:0]  amp0, amp1;
  logic [31:0] a0, a1, wd0, wd1;
  logic        gnt0, gnt1, mem_we;
  logic [31:0] rd0, rd1;
  logic [3:0]  mem_amp;
  logic [31:0] mem_a, mem_wd, mem_rd;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .we0(we0), .we1(we1), .amp0(amp0), .amp1(amp1),
    .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .rd0(rd0), .rd1(rd1),
    .mem_we(mem_we), .mem_amp(mem_amp), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  logic [31:0] mem [0:63];
  bit          init_done = 1'b0;
  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[8]    <= 32'h1234_5678;
      init_done <= 1'b1;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_amp[b]) mem[mem_a[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
    end
  end

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic        g0, g1, mwe;
    logic [3:0]  amp;
    logic [31:0] a, wd, r0, r1;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".gnt0"},  32'(gnt0),    32'(e.g0));
      chk({e.tag, ".gnt1"},  32'(gnt1),    32'(e.g1));
      chk({e.tag, ".we"},    32'(mem_we),  32'(e.mwe));
      chk({e.tag, ".amp"},   32'(mem_amp), 32'(e.amp));
      chk({e.tag, ".addr"},  mem_a,        e.a);
      chk({e.tag, ".wdata"}, mem_wd,       e.wd);
      chk({e.tag, ".rd0"},   rd0,          e.r0);
      chk({e.tag, ".rd1"},   rd1,          e.r1);
    end
  end

  function automatic logic [31:0] mrd(input logic [31:0] ad);
    return mem[ad[7:2]];
  endfunction

  task automatic step(input string tag, input logic g0, g1, mwe, input logic [3:0] amp,
                      input logic [31:0] ad, d, r0, r1);
    exp_t e;
    e.tag = tag; e.g0 = g0; e.g1 = g1; e.mwe = mwe; e.amp = amp;
    e.a = ad; e.wd = d; e.r0 = r0; e.r1 = r1;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic none(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic p0(input logic r, l, w, input logic [3:0] m, input logic [31:0] ad, d);
    req0 = r; lock0 = l; we0 = w; amp0 = m; a0 = ad; wd0 = d;
  endtask

  task automatic p1(input logic r, l, w, input logic [3:0] m, input logic [31:0] ad, d);
    req1 = r; lock1 = l; we1 = w; amp1 = m; a1 = ad; wd1 = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    p0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    p1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    none("rst");

    // word write then read-back on port 0
    p0(1, 0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
    none("w0_idle");
    step("w0", 1, 0, 1, 4'hF, 32'h10, 32'hDEAD_BEEF, mrd(32'h10), 32'h0);
    p0(1, 0, 0, 4'hF, 32'h10, 32'h0);
    step("r0", 1, 0, 0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0);
    p0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    none("r0_drop");
    none("idle1");

    // IDLE tie with last grant = port 0
    p0(1, 0, 0, 4'hF, 32'h10, 32'h0);
    p1(1, 0, 0, 4'hF, 32'h20, 32'h0);
    none("tie0_idle");
`ifdef DMEM_ARB_RR_EN
    step("tie0_rr", 0, 1, 0, 4'hF, 32'h20, 32'h0, 32'h0, 32'h1234_5678);
`else
    step("tie0_fix", 1, 0, 0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0);
`endif
    p0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    p1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    none("tie0_drop");
    none("idle2");

    // lone port-1 read so the last grant is port 1 in both builds
    p1(1, 0, 0, 4'hF, 32'h20, 32'h0);
    none("p1_idle");
    step("p1", 0, 1, 0, 4'hF, 32'h20, 32'h0, 32'h0, 32'h1234_5678);
    p1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    none("p1_drop");
    none("idle3");

    // tie with last grant = port 1: port 0 first, then strict alternation
    p0(1, 0, 0, 4'hF, 32'h10, 32'h0);
    p1(1, 0, 0, 4'hF, 32'h20, 32'h0);
    none("alt_idle");
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) step($sformatf("alt%0d", i), 1, 0, 0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0);
      else            step($sformatf("alt%0d", i), 0, 1, 0, 4'hF, 32'h20, 32'h0, 32'h0, 32'h1234_5678);
    end
    p0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    p1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    none("alt_drop");
    none("idle4");

    // locked owner is forced off after MAX_WAIT cycles
    p0(1, 1, 0, 4'hF, 32'h10, 32'h0);
    p1(1, 0, 0, 4'hF, 32'h20, 32'h0);
    none("lk_idle");
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("lk_wcnt%0d", k), 32'(dut.u_wait.r_cnt), 32'(k - 1));
      step($sformatf("lk0_%0d", k), 1, 0, 0, 4'hF, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0);
    end
    chk("lk_wcnt_sw", 32'(dut.u_wait.r_cnt), 32'h0);
    step("lk1", 0, 1, 0, 4'hF, 32'h20, 32'h0, 32'h0, 32'h1234_5678);
    p0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    p1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    none("lk_drop");
    none("idle5");

    // port-1 byte write, word write, then reset in the middle of the burst
    p1(1, 0, 1, 4'b0100, 32'h20, 32'h0000_00AB);
    none("b_idle");
    step("b_byte", 0, 1, 1, 4'b0100, 32'h20, 32'h0000_00AB, 32'h0, mrd(32'h20));
    p1(1, 0, 1, 4'hF, 32'h44, 32'h4444_4444);
    step("b_word", 0, 1, 1, 4'hF, 32'h44, 32'h4444_4444, 32'h0, mrd(32'h44));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    p1(1, 0, 1, 4'hF, 32'h48, 32'h0000_0055);
    none("rst_mid");
    p1(0, 0, 0, 4'h0, 32'h0, 32'h0);
    none("rst_mid2");
    none("idle6");
    chk("mem48", mem[18], 32'h0);
    chk("mem44", mem[17], 32'h4444_4444);
    chk("mem20", mem[8],  32'h1200_5678);

    // read the byte-patched word back through port 0
    p0(1, 0, 0, 4'hF, 32'h20, 32'h0);
    none("rb_idle");
    step("rb", 1, 0, 0, 4'hF, 32'h20, 32'h0, 32'h1200_5678, 32'h0);
    p0(0, 0, 0, 4'h0, 32'h0, 32'h0);
    none("rb_drop");

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 8, number of cycles a non-owner may wait behind a locked owner before a forced switch; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; every state element updates on its rising edge.
REQ-003 Port: reset  input  1  reset, synchronous and active-high.
REQ-004 Port: req0 / req1  input  1  requester 0 (CPU LSU) / requester 1 (loader/DMA) access request.
REQ-005 Port: lock0 / lock1  input  1  requester holds ownership across consecutive accesses while asserted with its req.
REQ-006 Port: we0 / we1  input  1  write enable of the requester's access.
REQ-007 Port: amp0 / amp1  input  4  byte-lane mask: 1111 word, 0011/1100 half, one-hot byte.
REQ-008 Port: a0 / a1, wd0 / wd1  input  XLEN  byte address and write data.
REQ-009 Port: gnt0 / gnt1  output  1  access performed this cycle: write commits at the next edge, read data valid now.
REQ-010 Port: rd0 / rd1  output  XLEN  read data returned to each requester.
REQ-011 Port: mem_we  output  1; mem_amp  output  4; mem_a, mem_wd  output  XLEN  drive the shared data memory.
REQ-012 Port: mem_rd  input  XLEN  combinational read data from the data memory.

Function
REQ-013 The FSM SHALL have states IDLE, OWN0, OWN1; gnt_i SHALL equal (state==OWNi && req_i); gnt0 and gnt1 SHALL never both be 1.
REQ-014 From IDLE: no grant; next state OWN0 if only req0, OWN1 if only req1, tie resolved per REQ-025/026, IDLE if neither; request-to-grant latency is 1 cycle.
REQ-015 In OWNi with req_i low: next state SHALL be OWNj if req_j, else IDLE.
REQ-016 In OWNi with req_i high, lock_i low, req_j high: next state SHALL be OWNj (one access, then alternate).
REQ-017 In OWNi with req_i high and (lock_i high or req_j low): state SHALL remain OWNi, except per REQ-019.
REQ-018 wait_cnt SHALL increment each cycle req_j is high while state==OWNi; it SHALL clear when req_j is low or on any state change.
REQ-019 When wait_cnt reaches MAX_WAIT-1 with req_j high, next state SHALL be OWNj regardless of lock_i.
REQ-020 mem_we SHALL be (gnt0&we0)|(gnt1&we1); mem_a, mem_wd, mem_amp SHALL mux from the granted port, and be all zero with mem_we=0 when no grant.
REQ-021 rd_i SHALL equal mem_rd when gnt_i, else zero; no data is registered.
REQ-022 last_gnt (1 bit) SHALL record the index of the most recent granted port.
REQ-023 Requesters SHALL hold req, we, amp, a, wd stable until gnt; the arbiter need not check this.

Reset
REQ-024 While reset is high at an edge: state=IDLE, wait_cnt=0, last_gnt=1; hence gnt0=gnt1=0, mem_we=0, rd0=rd1=0 in the following cycle; reset asserted mid-burst SHALL drop ownership with no write committed in the reset cycle's successor.

Configuration
REQ-025 With DMEM_ARB_RR_EN defined: an IDLE tie SHALL grant the port not equal to last_gnt (round-robin).
REQ-026 Without DMEM_ARB_RR_EN: an IDLE tie SHALL always grant port 0 (fixed priority); REQ-016/019 still apply.

Structure
REQ-027 State encodings (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10) and the default MAX_WAIT SHALL live in the shared defines file alongside XLEN and ADDR_SIZE.
REQ-028 One sub-module, arb_wait_counter (clear, inc, saturate-at-threshold flag output), SHALL implement wait_cnt; all else is in dmem_arbiter.

Verification
REQ-029 Reset then req0=1, we0=1, a0=0x10, wd0=0xDEADBEEF, amp0=1111 -> gnt0=1 in cycle 2, mem_we=1, mem_a=0x10; a subsequent read of 0x10 returns rd0=0xDEADBEEF.
REQ-030 req0 and req1 rise together from IDLE after reset -> OWN0 first (both configs); unlocked, grants alternate 0,1,0,1 each cycle.
REQ-031 RR build: port 1 granted last, arbiter idle, then both request -> gnt0 first; fixed build same stimulus -> gnt0 first; with last_gnt=0 RR gives gnt1, fixed gives gnt0.
REQ-032 lock0 held with req0, req1 high, MAX_WAIT=8 -> gnt0 for 8 cycles, then gnt1 on cycle 9 with wait_cnt back to 0.
REQ-033 Reset asserted during OWN1 write burst -> next cycle gnt1=0, mem_we=0, memory unchanged at the burst address.
REQ-034 amp1=0100, wd1=0x000000AB, a1=0x20 write -> mem_amp=0100, mem_wd=0x000000AB routed unchanged; gnt0=0 throughout.
